// File: rtl/pipe_seg_skid.sv
// Parametrised pipeline-segment register with valid/ready on both sides,
// an optional one-entry skid buffer and an occupancy count.
module pipe_seg_skid #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              refresh,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              r_m_v;
  logic [DATA_W-1:0] r_m_d;
  logic              w_s_v;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;

  assign w_out_fire = r_m_v & out_ready & ~stall;
  assign w_in_fire  = in_valid & w_in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_s_v;
      logic [DATA_W-1:0] r_s_d;

      // S only ever fills while M is full, so an empty M implies an empty S.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_m_v <= 1'b0;
          r_m_d <= '0;
          r_s_v <= 1'b0;
          r_s_d <= '0;
        end else if (refresh) begin
          r_m_v <= 1'b0;
          r_m_d <= '0;
          r_s_v <= 1'b0;
          r_s_d <= '0;
        end else if (!r_m_v) begin
          if (w_in_fire) begin
            r_m_v <= 1'b1;
            r_m_d <= in_data;
          end
        end else if (w_out_fire) begin
          if (r_s_v) begin
            r_m_v <= 1'b1;
            r_m_d <= r_s_d;
            r_s_v <= 1'b0;
            r_s_d <= '0;
          end else if (w_in_fire) begin
            r_m_v <= 1'b1;
            r_m_d <= in_data;
          end else begin
            r_m_v <= 1'b0;
            r_m_d <= '0;
          end
        end else if (w_in_fire) begin
          r_s_v <= 1'b1;
          r_s_d <= in_data;
        end
      end

      assign w_s_v      = r_s_v;
      assign w_in_ready = ~r_s_v;
    end else begin : g_noskid
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_m_v <= 1'b0;
          r_m_d <= '0;
        end else if (refresh) begin
          r_m_v <= 1'b0;
          r_m_d <= '0;
        end else if (!r_m_v || w_out_fire) begin
          if (w_in_fire) begin
            r_m_v <= 1'b1;
            r_m_d <= in_data;
          end else begin
            r_m_v <= 1'b0;
            r_m_d <= '0;
          end
        end
      end

      // Combinational path: a slot frees in the same cycle the payload leaves.
      assign w_s_v      = 1'b0;
      assign w_in_ready = ~r_m_v | w_out_fire;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = r_m_v;
  assign out_data  = r_m_d;
  assign count     = {1'b0, r_m_v} + {1'b0, w_s_v};

endmodule

// File: tb/tb_pipe_seg_skid.sv
// Directed bench for pipe_seg_skid: one SKID=1 and one SKID=0 instance,
// payload ordering checked by a scoreboard queue per instance.
module tb_pipe_seg_skid;
  localparam int W = 16;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic refresh = 1'b0;
  logic stall = 1'b0;

  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [W-1:0] a_in_data = '0, a_out_data;
  logic [1:0]   a_count;
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [W-1:0] b_in_data = '0, b_out_data;
  logic [1:0]   b_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];

  always #5 clk = ~clk;

  pipe_seg_skid #(.DATA_W(W), .SKID(1)) dut_a (
    .clk(clk), .resetn(resetn), .refresh(refresh), .stall(stall),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count));

  pipe_seg_skid #(.DATA_W(W), .SKID(0)) dut_b (
    .clk(clk), .resetn(resetn), .refresh(refresh), .stall(stall),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop on out_fire before pushing on in_fire (output is always older).
  always @(negedge clk) begin
    if (!resetn || refresh) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_out_valid && a_out_ready && !stall) begin
        if (qa.size() == 0) begin
          n_cmp++; n_bad++;
          $error("FAIL a_unexpected_out observed=%0h expected=none", a_out_data);
        end else chk("a_out_order", a_out_data, qa.pop_front());
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_out_valid && b_out_ready && !stall) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $error("FAIL b_unexpected_out observed=%0h expected=none", b_out_data);
        end else chk("b_out_order", b_out_data, qb.pop_front());
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    end
  end

  initial begin
    // reset state
    #2 resetn = 1'b0;
    #10;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_count", b_count, 0);
    step();
    resetn = 1'b1;

    // streaming 1..4 through both
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 1'b1; a_in_data = W'(i);
      b_in_valid = 1'b1; b_in_data = W'(i);
      step();
      chk("strm_a_data", a_out_data, i);
      chk("strm_a_valid", a_out_valid, 1);
      chk("strm_a_count", a_count, 1);
      chk("strm_a_in_ready", a_in_ready, 1);
      chk("strm_b_data", b_out_data, i);
      chk("strm_b_count", b_count, 1);
      chk("strm_b_in_ready", b_in_ready, 1);
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    step();
    chk("strm_a_drain", a_out_valid, 0);
    chk("strm_b_drain", b_out_valid, 0);
    chk("strm_a_drain_data", a_out_data, 0);

    // skid fill
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h000A;
    step();
    chk("skid_a_count1", a_count, 1);
    a_in_data = 16'h000B;
    step();
    chk("skid_a_count2", a_count, 2);
    chk("skid_a_in_ready", a_in_ready, 0);
    chk("skid_a_data", a_out_data, 16'h000A);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    step();
    chk("skid_a_second", a_out_data, 16'h000B);
    chk("skid_a_count_after", a_count, 1);
    chk("skid_a_in_ready_after", a_in_ready, 1);
    step();
    chk("skid_a_empty", a_out_valid, 0);

    // stall
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0005;
    step();
    a_in_valid = 1'b0; stall = 1'b1; a_out_ready = 1'b1;
    step();
    chk("stall_a_hold1", a_out_data, 16'h0005);
    chk("stall_a_valid1", a_out_valid, 1);
    a_in_valid = 1'b1; a_in_data = 16'h0006;
    step();
    chk("stall_a_hold2", a_out_data, 16'h0005);
    chk("stall_a_count2", a_count, 2);
    a_in_valid = 1'b0;
    step();
    chk("stall_a_hold3", a_out_data, 16'h0005);
    chk("stall_a_count3", a_count, 2);
    stall = 1'b0;
    step();
    chk("stall_a_next", a_out_data, 16'h0006);
    chk("stall_a_count_rel", a_count, 1);
    step();
    chk("stall_a_empty", a_out_valid, 0);

    // refresh with count=2
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0007;
    step();
    a_in_data = 16'h0008;
    step();
    chk("ref_a_pre_count", a_count, 2);
    refresh = 1'b1; a_out_ready = 1'b1; a_in_data = 16'h0009;
    step();
    refresh = 1'b0; a_in_valid = 1'b0;
    chk("ref_a_count", a_count, 0);
    chk("ref_a_valid", a_out_valid, 0);
    chk("ref_a_data", a_out_data, 0);
    chk("ref_a_in_ready", a_in_ready, 1);

    // refresh with simultaneous in_fire/out_fire
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 16'h0010;
    b_in_valid = 1'b1; b_in_data = 16'h0020;
    step();
    refresh = 1'b1; a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_in_data = 16'h0011; b_in_data = 16'h0021;
    #1;
    chk("ref2_a_both_fire", a_in_ready & a_out_valid, 1);
    chk("ref2_b_both_fire", b_in_ready & b_out_valid, 1);
    step();
    refresh = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    chk("ref2_a_count", a_count, 0);
    chk("ref2_a_data", a_out_data, 0);
    chk("ref2_b_count", b_count, 0);
    chk("ref2_b_valid", b_out_valid, 0);
    step();
    step();
    chk("ref2_a_no_stale", a_out_valid, 0);
    chk("ref2_b_no_stale", b_out_valid, 0);
    a_in_valid = 1'b1; a_in_data = 16'h0012;
    step();
    a_in_valid = 1'b0;
    chk("ref2_a_fresh", a_out_data, 16'h0012);
    step();

    // SKID=0: combinational in_ready
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 16'h0030;
    step();
    chk("s0_b_in_ready_full", b_in_ready, 0);
    chk("s0_b_count_full", b_count, 1);
    b_in_data = 16'h0031;
    step();
    chk("s0_b_hold", b_out_data, 16'h0030);
    b_out_ready = 1'b1;
    #1;
    chk("s0_b_in_ready_same", b_in_ready, 1);
    step();
    b_in_valid = 1'b0;
    chk("s0_b_replaced", b_out_data, 16'h0031);
    chk("s0_b_count", b_count, 1);
    step();
    chk("s0_b_empty", b_out_valid, 0);

    // asynchronous reset with count=2
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 16'h0040;
    step();
    a_in_data = 16'h0041;
    step();
    a_in_valid = 1'b0;
    chk("arst_a_pre_count", a_count, 2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_a_valid", a_out_valid, 0);
    chk("arst_a_count", a_count, 0);
    step();
    resetn = 1'b1;
    step();
    chk("arst_a_in_ready", a_in_ready, 1);
    chk("arst_b_in_ready", b_in_ready, 1);
    chk("arst_a_stays_empty", a_out_valid, 0);

    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
